ssd_scan_driver: RTL and testbench

//  Display-side end of the lock's 20-bit symbol bus: accepts four 5-bit symbol codes plus a
//  per-digit blink mask, time-multiplexes them onto a 4-digit common-anode seven-segment display.

---
 rtl/ssd_pkg.sv | 24 ++
 rtl/ssd_sym_to_seg.sv | 37 +++
 rtl/ssd_scan_driver.sv | 123 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display path: symbol codes,
// segment constants and scan/blink state types.
package ssd_pkg;

  localparam logic [4:0] SYM_L     = 5'h10;
  localparam logic [4:0] SYM_O     = 5'h11;
  localparam logic [4:0] SYM_P     = 5'h12;
  localparam logic [4:0] SYM_N     = 5'h13;
  localparam logic [4:0] SYM_TIRE  = 5'h14;
  localparam logic [4:0] SYM_BLANK = 5'h15;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  typedef enum logic {
    VISIBLE = 1'b0,
    HIDDEN  = 1'b1
  } blink_phase_t;

endpackage

// File: rtl/ssd_sym_to_seg.sv
// Combinational 5-bit symbol code to active-low {g,f,e,d,c,b,a} segments.
module ssd_sym_to_seg
  import ssd_pkg::*;
(
  input  logic [4:0] sym,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (sym)
      5'h00:    seg = 7'h40;
      5'h01:    seg = 7'h79;
      5'h02:    seg = 7'h24;
      5'h03:    seg = 7'h30;
      5'h04:    seg = 7'h19;
      5'h05:    seg = 7'h12;
      5'h06:    seg = 7'h02;
      5'h07:    seg = 7'h78;
      5'h08:    seg = 7'h00;
      5'h09:    seg = 7'h10;
      5'h0A:    seg = 7'h08;
      5'h0B:    seg = 7'h03;
      5'h0C:    seg = 7'h46;
      5'h0D:    seg = 7'h21;
      5'h0E:    seg = 7'h06;
      5'h0F:    seg = 7'h0E;
      SYM_L:    seg = 7'h47;
      SYM_O:    seg = 7'h40;
      SYM_P:    seg = 7'h0C;
      SYM_N:    seg = 7'h2B;
      SYM_TIRE: seg = 7'h3F;
      default:  seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver with per-digit blink and shadowed,
// frame-synchronous symbol updates.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 25_000,
  parameter int unsigned BLINK_TICKS = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] sym_in,
  input  logic [3:0]  blink_mask,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned SW = $clog2(DIGIT_TICKS + 1);
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);

  scan_state_t  state, state_nxt;
  blink_phase_t phase;
  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    idx, idx_nxt;
  logic [19:0]   act_sym, shadow_sym;
  logic [3:0]    act_mask, shadow_mask;
  logic [4:0]    cur_sym;
  logic [6:0]    cur_seg;
  logic          slot_last, blink_last;

  assign slot_last  = (slot_cnt == SW'(DIGIT_TICKS - 1));
  assign blink_last = (blink_cnt == BW'(BLINK_TICKS - 1));
  assign frame_done = (state == DRIVE) && slot_last && (idx == 2'd0);
  assign cur_sym    = act_sym[idx*5 +: 5];

  ssd_sym_to_seg u_dec (
    .sym (cur_sym),
    .seg (cur_seg)
  );

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt + SW'(1);
    idx_nxt   = idx;
    case (state)
      GAP:   state_nxt = DRIVE;
      DRIVE: begin
        if (slot_last) begin
          state_nxt = GAP;
          slot_nxt  = '0;
          idx_nxt   = idx - 2'd1;
        end
      end
      default: state_nxt = GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= GAP;
      slot_cnt <= '0;
      idx      <= 2'd3;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_nxt;
      idx      <= idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= VISIBLE;
    end else if (blink_last) begin
      blink_cnt <= '0;
      phase     <= (phase == VISIBLE) ? HIDDEN : VISIBLE;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // A load landing on the boundary cycle bypasses the shadow so it is not
  // deferred a whole frame and pending never flickers high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_sym     <= {4{SYM_BLANK}};
      act_mask    <= '0;
      shadow_sym  <= {4{SYM_BLANK}};
      shadow_mask <= '0;
      pending     <= 1'b0;
    end else if (frame_done) begin
      if (load) begin
        act_sym  <= sym_in;
        act_mask <= blink_mask;
      end else if (pending) begin
        act_sym  <= shadow_sym;
        act_mask <= shadow_mask;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow_sym  <= sym_in;
      shadow_mask <= blink_mask;
      pending     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else if (state == DRIVE) begin
      an  <= ~(4'b0001 << idx);
      seg <= (phase == HIDDEN && act_mask[idx]) ? SEG_OFF : cur_seg;
    end else begin
      an  <= '1;
      seg <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized self-checking bench for ssd_scan_driver against a time-indexed
// reference model of the scan, blink and frame-update rules.
module tb_ssd_scan_driver;

  localparam int DT = 4;
  localparam int BT = 40;
  localparam int FR = 4 * DT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] sym_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        load = 1'b0;
  logic        pending, frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: k = clock edges since reset release; everything else follows from it.
  int         k;
  logic [4:0] m_act [4];
  logic [4:0] m_sh  [4];
  logic [3:0] m_mask, m_shmask;
  logic       m_pend;

  ssd_scan_driver #(.DIGIT_TICKS(DT), .BLINK_TICKS(BT)) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_in     (sym_in),
    .blink_mask (blink_mask),
    .load       (load),
    .pending    (pending),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [4:0] c);
    logic [6:0] lit [22];
    lit = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
            7'h38, 7'h3F, 7'h73, 7'h54, 7'h40, 7'h00};
    if (c > 5'h15) return 7'h7F;
    return ~lit[c];
  endfunction

  function automatic logic [19:0] pack4(input logic [4:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, k);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 5'h15;
      m_sh[i]  = 5'h15;
    end
    m_mask   = '0;
    m_shmask = '0;
    m_pend   = 1'b0;
  endtask

  task automatic step(input logic r, input logic ld, input logic [19:0] s, input logic [3:0] bm);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int pos, slot, dig;
    logic bnd, hidden;
    rst = r; load = ld; sym_in = s; blink_mask = bm;
    @(posedge clk);
    if (!r) begin
      e_an = 4'hF; e_seg = 7'h7F;
      model_reset();
    end else begin
      pos    = k % FR;
      slot   = pos % DT;
      dig    = 3 - pos / DT;
      hidden = ((k / BT) % 2) == 1;
      if (slot == 0) begin
        e_an = 4'hF; e_seg = 7'h7F;
      end else begin
        e_an  = ~(4'b0001 << dig);
        e_seg = (hidden && m_mask[dig]) ? 7'h7F : ref_seg(m_act[dig]);
      end
      bnd = (pos == FR - 1);
      if (bnd) begin
        if (ld) begin
          for (int i = 0; i < 4; i++) m_act[i] = s[i*5 +: 5];
          m_mask = bm;
        end else if (m_pend) begin
          for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
          m_mask = m_shmask;
        end
        m_pend = 1'b0;
      end else if (ld) begin
        for (int i = 0; i < 4; i++) m_sh[i] = s[i*5 +: 5];
        m_shmask = bm;
        m_pend   = 1'b1;
      end
      k++;
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("pending", 32'(pending), 32'(m_pend));
    check("frame_done", 32'(frame_done), 32'(r && (k % FR) == FR - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, sym_in, blink_mask);
  endtask

  // Advance until the model sits at the given frame position (bounded to one frame).
  task automatic idle_to(input int p);
    for (int i = 0; i < FR && (k % FR) != p; i++) step(1'b1, 1'b0, sym_in, blink_mask);
  endtask

  initial begin
    logic r, ld;
    logic [19:0] s;
    logic [3:0] bm;
    model_reset();

    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    idle(3);

    step(1'b1, 1'b1, pack4(5'h01, 5'h02, 5'h03, 5'h04), 4'b0000);
    idle(3 * FR);

    idle_to(DT + 1);
    step(1'b1, 1'b1, pack4(5'h10, 5'h11, 5'h12, 5'h13), 4'b0000);
    idle(2 * FR);

    step(1'b1, 1'b1, pack4(5'h08, 5'h09, 5'h0A, 5'h0B), 4'b0001);
    idle(12 * FR);

    idle_to(FR - 1);
    step(1'b1, 1'b1, pack4(5'h14, 5'h15, 5'h15, 5'h00), 4'b0000);
    idle(FR);

    idle_to(1);
    step(1'b1, 1'b1, pack4(5'h0C, 5'h0D, 5'h0E, 5'h0F), 4'b1111);
    idle(3);
    step(1'b1, 1'b1, pack4(5'h05, 5'h06, 5'h07, 5'h1F), 4'b0100);
    idle(2 * FR);

    step(1'b1, 1'b1, pack4(5'h02, 5'h02, 5'h02, 5'h02), 4'b0000);
    idle_to(2 * DT + 2);
    step(1'b0, 1'b0, sym_in, blink_mask);
    idle(2 * FR);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) != 0);
      ld = ($urandom_range(0, 15) == 0) ||
           (((k % FR) == FR - 1) && ($urandom_range(0, 2) == 0));
      s  = 20'($urandom);
      bm = 4'($urandom);
      step(r, ld, s, bm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
